// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state and overlay encodings for the pong game controller
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam logic [1:0] TXT_LOGO    = 2'b00;
  localparam logic [1:0] TXT_SCORE   = 2'b01;
  localparam logic [1:0] TXT_NEWBALL = 2'b10;
  localparam logic [1:0] TXT_OVER    = 2'b11;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - player/timer inputs and display outputs of the game controller
interface pong_game_ctrl_if;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       timer_up;
  logic       timer_start;
  logic       graph_still;
  logic [1:0] text_sel;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [1:0] balls_left;

  // master drives the game events, slave is the controller
  modport master (
    output btn, hit, miss, timer_up,
    input  timer_start, graph_still, text_sel, dig1, dig0, balls_left
  );

  modport slave (
    input  btn, hit, miss, timer_up,
    output timer_start, graph_still, text_sel, dig1, dig0, balls_left
  );
endinterface

// File: rtl/pong_bcd_counter.sv
// rtl/pong_bcd_counter.sv - two-digit BCD score counter, 99 wraps to 00; carry0 flags units wrap
module pong_bcd_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       carry0
);

  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;

  assign carry0 = inc && !clr && (dig0_q == 4'd9);

  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (clr) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc) begin
      if (dig0_q == 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game flow FSM, score and ball bookkeeping
// PONG_EXTRA_BALL_EN: award a ball each time the score units digit wraps 9->0
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_BALLS = 3
) (
  input logic          clk,
  input logic          reset,
  pong_game_ctrl_if.slave gif
);

  localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
  localparam logic [1:0] BALLS_MAX  = 2'(NUM_BALLS - 1);

  state_e     state_q, state_d;
  logic [1:0] balls_q, balls_d;
  logic       btn_any, in_play, score_inc, score_clr, score_carry;

  assign btn_any   = |gif.btn;
  assign in_play   = (state_q == ST_PLAY);
  // a miss wins over a simultaneous hit
  assign score_inc = in_play && gif.hit && !gif.miss;
  assign score_clr = (state_q == ST_NEWGAME) && btn_any;

  pong_bcd_counter u_score (
    .clk    (clk),
    .reset  (reset),
    .inc    (score_inc),
    .clr    (score_clr),
    .dig1   (gif.dig1),
    .dig0   (gif.dig0),
    .carry0 (score_carry)
  );

  always_comb begin
    state_d = state_q;
    balls_d = balls_q;
    case (state_q)
      ST_NEWGAME: begin
        if (btn_any) begin
          state_d = ST_PLAY;
          balls_d = BALLS_MAX;
        end
      end
      ST_PLAY: begin
        if (gif.miss) begin
          if (balls_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_NEWBALL;
            balls_d = balls_q - 2'd1;
          end
        end
`ifdef PONG_EXTRA_BALL_EN
        else if (score_carry && (balls_q < BALLS_MAX)) begin
          balls_d = balls_q + 2'd1;
        end
`endif
      end
      // the button only counts once the serve delay has elapsed
      ST_NEWBALL: begin
        if (gif.timer_up && btn_any) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (gif.timer_up) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

`ifndef PONG_EXTRA_BALL_EN
  logic carry_unused;
  assign carry_unused = score_carry;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      balls_q <= BALLS_INIT;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
    end
  end

  assign gif.timer_start = in_play && gif.miss;
  assign gif.graph_still = !in_play;
  assign gif.balls_left  = balls_q;

  always_comb begin
    gif.text_sel = TXT_LOGO;
    case (state_q)
      ST_NEWGAME: gif.text_sel = TXT_LOGO;
      ST_PLAY:    gif.text_sel = TXT_SCORE;
      ST_NEWBALL: gif.text_sel = TXT_NEWBALL;
      ST_OVER:    gif.text_sel = TXT_OVER;
      default:    gif.text_sel = TXT_LOGO;
    endcase
  end

endmodule
